// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Bundles the two handshaked buses of the instruction fetch stage:
//   - instruction memory bus (req/gnt/rvalid)
//       imem_req_o     fetch request
//       imem_addr_o    word-aligned fetch address
//       imem_gnt_i     request accepted this cycle
//       imem_rvalid_i  response valid, returned in request order
//       imem_rdata_i   response instruction
//   - decode bus (valid/ready)
//       valid_o        instr_o/pc_o hold a valid instruction
//       ready_i        decode accepts this cycle
//       instr_o        instruction to decode
//       pc_o           PC of instr_o
// Signal names carry the direction as seen from the fetch stage.
// Modports:
//   master : fetch stage side
//   slave  : environment side (memory + decode)
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output valid_o,
        input  ready_i,
        output instr_o,
        output pc_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  valid_o,
        output ready_i,
        input  instr_o,
        input  pc_o
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage. Owns the fetch PC, issues requests to instruction
// memory, buffers returned instructions in a small FIFO and hands them to
// decode. Redirects from later stages flush the buffer and squash responses
// that are still in flight.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  new fetch address (must be word aligned)
//   error_o        sticky misaligned-redirect error
//   fetch_bus      if_stage_if.master (imem req/gnt/rvalid + decode valid/ready)
//
// Handshakes:
//   imem:   a request transfers on a cycle where imem_req_o && imem_gnt_i;
//           while not granted, imem_req_o/imem_addr_o hold unless a redirect
//           occurs. imem_rvalid_i returns one response per granted request,
//           in request order.
//   decode: an instruction transfers on a cycle where valid_o && ready_i;
//           instr_o/pc_o are stable while valid_o is high and not accepted,
//           unless a redirect flushes them.
//
// Build option:
//   IF_STAGE_BYPASS_EN  when defined, a response arriving at an empty buffer
//                       with nothing to discard is forwarded to decode in the
//                       same cycle (zero-cycle latency).
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              error_o,
    if_stage_if.master        fetch_bus
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]      pc_q, pc_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] count_q, count_d;        // buffer occupancy
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;    // in-flight responses to drop
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
    logic [PTR_W-1:0] tag_rd_q, tag_rd_d;

    // Storage (data only, no reset needed: qualified by count/outstanding)
    logic [31:0] instr_mem_q [FIFO_DEPTH];
    logic [31:0] pc_mem_q    [FIFO_DEPTH];
    logic [31:0] tag_mem_q   [FIFO_DEPTH];     // PC of each outstanding request

    logic [CNT_W:0] credit_used;
    logic           req;
    logic           gnt_fire;
    logic           rsp_fire;
    logic           fifo_valid;
    logic           fifo_pop;
    logic           push;
    logic           bypass;
    logic [31:0]    rsp_pc;

    // Buffer slots plus outstanding requests never exceed FIFO_DEPTH, so
    // every response always has a slot waiting for it. Request is held low
    // while in reset so the bus sees a quiet fetch stage.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign req         = rst_n && !error_q && (credit_used < DEPTH_C);
    assign gnt_fire    = req && fetch_bus.imem_gnt_i;
    // A response with nothing outstanding is a protocol violation; ignore it.
    assign rsp_fire    = fetch_bus.imem_rvalid_i && (outstanding_q != '0);
    assign rsp_pc      = tag_mem_q[tag_rd_q];
    assign fifo_valid  = (count_q != '0);
    assign fifo_pop    = fifo_valid && fetch_bus.ready_i;

`ifdef IF_STAGE_BYPASS_EN
    // Forward only a response that would otherwise be pushed into an empty
    // buffer; a response in a redirect cycle belongs to the old stream.
    assign bypass = !fifo_valid && (discard_q == '0) && rsp_fire && !redirect_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = rsp_fire && !redirect_i && (discard_q == '0) &&
                  !(bypass && fetch_bus.ready_i);

    // Next-state logic
    always_comb begin
        pc_d          = pc_q;
        error_d       = error_q;
        count_d       = count_q;
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rsp_fire);

        if (gnt_fire) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = tag_wr_q + PTR_W'(1);
        end
        if (rsp_fire) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
        end

        if (redirect_i) begin
            // Everything still in flight after this cycle's accounting
            // belongs to the old stream and is dropped as it returns.
            pc_d      = redirect_pc_i;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            discard_d = outstanding_d;
            if (redirect_pc_i[1:0] != 2'b00) begin
                error_d = 1'b1;
            end
        end else begin
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            error_q       <= 1'b0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            error_q       <= error_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
        if (push) begin
            instr_mem_q[wr_ptr_q] <= fetch_bus.imem_rdata_i;
            pc_mem_q[wr_ptr_q]    <= rsp_pc;
        end
    end

    // Outputs
    assign fetch_bus.imem_req_o  = req;
    assign fetch_bus.imem_addr_o = pc_q;
    assign error_o               = error_q;

    always_comb begin
        fetch_bus.valid_o = fifo_valid || bypass;
        fetch_bus.instr_o = NOP_INSTR;
        fetch_bus.pc_o    = RESET_PC;
        if (fifo_valid) begin
            fetch_bus.instr_o = instr_mem_q[rd_ptr_q];
            fetch_bus.pc_o    = pc_mem_q[rd_ptr_q];
        end else if (bypass) begin
            fetch_bus.instr_o = fetch_bus.imem_rdata_i;
            fetch_bus.pc_o    = rsp_pc;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage (default build, FIFO_DEPTH = 2, RESET_PC = 0).
// Each cycle: inputs are applied 1 time unit after the rising edge, outputs
// are sampled 1 more unit later, then the next rising edge is taken.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        error;

    always #5 clk = ~clk;

    if_stage_if fetch_bus ();

    if_stage #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .error_o       (error),
        .fetch_bus     (fetch_bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Instruction word the memory returns for a given address
    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs and let combinational outputs settle.
    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdr, input logic [31:0] rpc);
        fetch_bus.imem_gnt_i    = g;
        fetch_bus.imem_rvalid_i = rv;
        fetch_bus.imem_rdata_i  = rd;
        fetch_bus.ready_i       = rdy;
        redirect                = rdr;
        redirect_pc             = rpc;
        #1;
        // A kept response must always find a free buffer slot.
        if (rst_n && rv && (dut.discard_q == '0) && !rdr) begin
            chk("no_full_push", 32'(int'(dut.count_q) < FIFO_DEPTH), 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins);
        chk({tag, "_valid"}, 32'(fetch_bus.valid_o), 32'(v));
        if (v) begin
            chk({tag, "_pc"}, fetch_bus.pc_o, pc);
            chk({tag, "_instr"}, fetch_bus.instr_o, ins);
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, 32'(fetch_bus.imem_req_o), 32'(r));
        if (r) chk({tag, "_addr"}, fetch_bus.imem_addr_o, a);
    endtask

    initial begin
        // ---------------- reset values ----------------
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        tick();
        chk("rst_req",   32'(fetch_bus.imem_req_o), 32'd0);
        chk("rst_valid", 32'(fetch_bus.valid_o), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_instr", fetch_bus.instr_o, NOP_INSTR);
        chk("rst_pc",    fetch_bus.pc_o, RESET_PC);
        chk("rst_addr",  fetch_bus.imem_addr_o, RESET_PC);

        // ---------------- streaming, ready=1 ----------------
        rst_n = 1'b1;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_req("s0", 1, 32'h0);
        chk_out("s0", 0, 0, 0);
        tick();                                   // grant 0
        drive(1, 1, dat(32'h0), 1, 0, 32'h0);
        chk_out("s1", 0, 0, 0);
        chk_req("s1", 1, 32'h4);
        tick();                                   // grant 4, resp 0
        drive(1, 1, dat(32'h4), 1, 0, 32'h0);
        chk_out("s2", 1, 32'h0, dat(32'h0));
        chk_req("s2", 0, 0);                      // credits exhausted
        tick();                                   // resp 4, pop 0
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_out("s3", 1, 32'h4, dat(32'h4));
        chk_req("s3", 1, 32'h8);
        tick();                                   // grant 8, pop 4
        drive(1, 1, dat(32'h8), 1, 0, 32'h0);
        chk_out("s4", 0, 0, 0);
        chk_req("s4", 1, 32'hC);
        tick();                                   // grant 12, resp 8
        drive(0, 1, dat(32'hC), 1, 0, 32'h0);
        chk_out("s5", 1, 32'h8, dat(32'h8));
        tick();                                   // resp 12, pop 8
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_out("s6", 1, 32'hC, dat(32'hC));
        chk_req("s6", 1, 32'h10);
        tick();                                   // pop 12

        // ---------------- backpressure, ready=0 for 10 cycles ----------------
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        chk_out("b0", 0, 0, 0);
        chk_req("b0", 1, 32'h10);
        tick();                                   // grant 16
        drive(1, 1, dat(32'h10), 0, 0, 32'h0);
        chk_req("b1", 1, 32'h14);
        tick();                                   // grant 20, resp 16
        drive(1, 1, dat(32'h14), 0, 0, 32'h0);
        chk_req("b2", 0, 0);
        chk_out("b2", 1, 32'h10, dat(32'h10));
        tick();                                   // resp 20, buffer full
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 32'h0, 0, 0, 32'h0);
            chk_req("bhold", 0, 0);
            chk_out("bhold", 1, 32'h10, dat(32'h10));
            chk("bhold_addr", fetch_bus.imem_addr_o, 32'h18);
            tick();
        end
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_out("d0", 1, 32'h10, dat(32'h10));
        chk_req("d0", 0, 0);
        tick();                                   // pop 16
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_out("d1", 1, 32'h14, dat(32'h14));
        chk_req("d1", 1, 32'h18);
        tick();                                   // grant 24, pop 20
        drive(0, 1, dat(32'h18), 1, 0, 32'h0);
        chk_out("d2", 0, 0, 0);
        tick();                                   // resp 24
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_out("d3", 1, 32'h18, dat(32'h18));
        tick();                                   // pop 24

        // ---------------- redirect with 2 outstanding ----------------
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_req("r0", 1, 32'h1C);
        tick();                                   // grant 28
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_req("r1", 1, 32'h20);
        tick();                                   // grant 32
        drive(0, 0, 32'h0, 1, 1, 32'h100);
        chk_req("r2", 0, 0);
        tick();                                   // redirect, discard=2
        drive(1, 1, dat(32'h1C), 1, 0, 32'h0);
        chk_out("r3", 0, 0, 0);
        chk_req("r3", 0, 0);
        chk("r3_addr", fetch_bus.imem_addr_o, 32'h100);
        tick();                                   // resp 28 dropped
        drive(1, 1, dat(32'h20), 1, 0, 32'h0);
        chk_out("r4", 0, 0, 0);
        chk_req("r4", 1, 32'h100);
        tick();                                   // grant 0x100, resp 32 dropped
        drive(0, 1, dat(32'h100), 1, 0, 32'h0);
        chk_out("r5", 0, 0, 0);
        tick();                                   // resp 0x100 kept
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk_out("r6", 1, 32'h100, dat(32'h100));
        tick();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_out("r7", 1, 32'h100, dat(32'h100));
        tick();                                   // pop 0x100

        // ---------------- redirect coinciding with gnt and rvalid ----------------
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_req("g0", 1, 32'h104);
        tick();                                   // grant 0x104
        drive(1, 1, dat(32'h104), 1, 1, 32'h200);
        chk_req("g1", 1, 32'h108);
        tick();                                   // grant 0x108 + resp 0x104, discard=1
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_out("g2", 0, 0, 0);
        chk_req("g2", 1, 32'h200);
        tick();
        drive(1, 1, dat(32'h108), 1, 0, 32'h0);
        chk_out("g3", 0, 0, 0);
        chk_req("g3", 1, 32'h200);
        tick();                                   // grant 0x200, resp 0x108 dropped
        drive(0, 1, dat(32'h200), 1, 0, 32'h0);
        chk_out("g4", 0, 0, 0);
        tick();                                   // resp 0x200 kept
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_out("g5", 1, 32'h200, dat(32'h200));
        tick();                                   // pop 0x200

        // ---------------- misaligned redirect ----------------
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_req("e0", 1, 32'h204);
        tick();                                   // grant 0x204
        drive(0, 0, 32'h0, 1, 1, 32'h102);
        chk("e1_error", 32'(error), 32'd0);
        tick();
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk("e2_error", 32'(error), 32'd1);
        chk_req("e2", 0, 0);
        chk_out("e2", 0, 0, 0);
        tick();
        drive(1, 1, dat(32'h204), 1, 0, 32'h0);
        chk_req("e3", 0, 0);
        tick();                                   // in-flight resp absorbed
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h0, 1, 0, 32'h0);
            chk("ehold_error", 32'(error), 32'd1);
            chk_req("ehold", 0, 0);
            chk_out("ehold", 0, 0, 0);
            chk("ehold_instr", fetch_bus.instr_o, NOP_INSTR);
            tick();
        end

        // ---------------- reset clears the error ----------------
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("x0_error", 32'(error), 32'd0);
        tick();

        // ---------------- async reset with 2 outstanding ----------------
        rst_n = 1'b1;
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        chk_req("a0", 1, RESET_PC);
        tick();                                   // grant 0
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        chk_req("a1", 1, 32'h4);
        tick();                                   // grant 4
        rst_n = 1'b0;
        drive(0, 1, dat(32'h0), 0, 0, 32'h0);     // late response during reset
        chk("a2_req",   32'(fetch_bus.imem_req_o), 32'd0);
        chk("a2_addr",  fetch_bus.imem_addr_o, RESET_PC);
        chk("a2_valid", 32'(fetch_bus.valid_o), 32'd0);
        chk("a2_error", 32'(error), 32'd0);
        chk("a2_instr", fetch_bus.instr_o, NOP_INSTR);
        chk("a2_pc",    fetch_bus.pc_o, RESET_PC);
        tick();
        drive(0, 1, dat(32'h4), 0, 0, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk_req("a3", 1, RESET_PC);
        chk_out("a3", 0, 0, 0);
        tick();                                   // grant 0
        drive(0, 1, 32'h1234_5678, 1, 0, 32'h0);
        chk_out("a4", 0, 0, 0);
        tick();                                   // resp 0 kept
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_out("a5", 1, RESET_PC, 32'h1234_5678);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
